rs232_stream_tx: RTL and testbench

RS232_STREAM_TX -- requirements
Module: rs232_stream_tx

---
 rtl/rs232_stream_tx.sv | 132 +++++++++++++
 tb/tb_rs232_stream_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_stream_tx.sv
// ============================================================================
// Module      : rs232_stream_tx
// Description : Stream-to-UART transmitter, 8N1. One byte is taken per
//               stdin_stb/stdin_ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rs232_stream_tx #(
   parameter int CLOCK_FREQUENCY = 100000000,
   parameter int BAUD_RATE       = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] stdin,
   input  logic        stdin_stb,
   output logic        stdin_ack,
   output logic        tx
);

   localparam int C_DIVIDER = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int C_CNT_W   = (C_DIVIDER > 2) ? $clog2(C_DIVIDER) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_DIVIDER - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [2:0]           r_bit_idx, w_bit_idx_nxt;
   logic [7:0]           r_data, w_data_nxt;
   logic                 r_tx, w_tx_nxt;
   logic                 r_ack, w_ack_nxt;
   logic                 w_bit_end;
   logic                 w_unused_hi;

   // Upper stream bits carry nothing for the serial line.
   assign w_unused_hi = ^stdin[31:8];

   assign w_bit_end = (r_cnt == C_CNT_LAST);
   assign stdin_ack = r_ack;
   assign tx        = r_tx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_data    <= '0;
         r_tx      <= 1'b1;
         r_ack     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_data    <= w_data_nxt;
         r_tx      <= w_tx_nxt;
         r_ack     <= w_ack_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_data_nxt    = r_data;
      w_tx_nxt      = r_tx;
      w_ack_nxt     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tx_nxt  = 1'b1;
            w_ack_nxt = 1'b1;
            // A transfer needs the ack already visible to the producer.
            if (stdin_stb && r_ack) begin
               w_data_nxt  = stdin[7:0];
               w_ack_nxt   = 1'b0;
               w_tx_nxt    = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_cnt_nxt     = '0;
               w_bit_idx_nxt = 3'd0;
               w_tx_nxt      = r_data[0];
               w_state_nxt   = S_DATA;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_W'(1);
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_cnt_nxt = '0;
               if (r_bit_idx == 3'd7) begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_tx_nxt      = r_data[r_bit_idx + 3'd1];
               end
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_W'(1);
            end
         end
         S_STOP: begin
            w_tx_nxt = 1'b1;
            if (w_bit_end) begin
               w_cnt_nxt   = '0;
               w_ack_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_W'(1);
            end
         end
         default: begin
            w_tx_nxt    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_rs232_stream_tx.sv
// ============================================================================
// Module      : tb_rs232_stream_tx
// Description : Self-checking bench for rs232_stream_tx with a frame-timeline
//               model, a UART receiver and directed + randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rs232_stream_tx;

   localparam int D = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] stdin = 32'h0;
   logic        stdin_stb = 1'b0;
   logic        stdin_ack;
   logic        tx;

   always #5 clk = ~clk;

   rs232_stream_tx #(
      .CLOCK_FREQUENCY (1000),
      .BAUD_RATE       (100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stdin     (stdin),
      .stdin_stb (stdin_stb),
      .stdin_ack (stdin_ack),
      .tx        (tx)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame timeline model: a frame occupies 10*D edges from its transfer edge.
   int         n = 0;
   int         t0 = 0;
   bit         in_frame = 1'b0;
   bit         m_ack = 1'b0;
   logic [7:0] mbyte = 8'h0;
   logic [7:0] rx_exp[$];
   logic [7:0] rx_got[$];
   time        fall_q[$];

   always @(posedge clk) begin
      if (rst) begin
         n++;
         if (in_frame) begin
            if (n - t0 == 10*D) begin
               in_frame = 1'b0;
               m_ack    = 1'b1;
            end
         end else if (stdin_stb && m_ack) begin
            in_frame = 1'b1;
            t0       = n;
            mbyte    = stdin[7:0];
            rx_exp.push_back(stdin[7:0]);
            m_ack    = 1'b0;
         end else begin
            m_ack = 1'b1;
         end
      end
   end

   always @(negedge rst) begin
      if (in_frame) void'(rx_exp.pop_back());
      in_frame = 1'b0;
      m_ack    = 1'b0;
   end

   function automatic logic exp_tx();
      int b;
      if (!in_frame) return 1'b1;
      b = (n - t0) / D;
      if (b == 0) return 1'b0;
      if (b >= 9) return 1'b1;
      return mbyte[b-1];
   endfunction

   always @(negedge clk) begin
      chk("tx_cycle", {31'b0, tx}, {31'b0, exp_tx()});
      chk("ack_cycle", {31'b0, stdin_ack}, {31'b0, m_ack});
   end

   // UART receiver sampling mid-bit; abandons a frame if reset is seen.
   task automatic rx_wait(input int k, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         if (!rst) begin
            ok = 1'b0;
            return;
         end
      end
   endtask

   task automatic rx_frame();
      bit         ok;
      logic [7:0] b;
      b = 8'h0;
      fall_q.push_back($time);
      rx_wait(4, ok);
      if (!ok) return;
      chk("rx_start", {31'b0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         rx_wait(D, ok);
         if (!ok) return;
         b[i] = tx;
      end
      rx_wait(D, ok);
      if (!ok) return;
      chk("rx_stop", {31'b0, tx}, 32'd1);
      rx_got.push_back(b);
      if (rx_exp.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL rx_unexpected: got byte 0x%0h, expected no frame", b);
      end else begin
         chk("rx_byte", {24'b0, b}, {24'b0, rx_exp.pop_front()});
      end
   endtask

   initial begin
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst && prev && !tx) rx_frame();
         prev = tx;
      end
   end

   task automatic send_check(input logic [31:0] word, input logic [9:0] pat, input string name);
      int bad;
      bad = 0;
      @(negedge clk);
      stdin     = word;
      stdin_stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      stdin_stb = 1'b0;
      stdin     = $urandom;
      for (int k = 0; k < 10*D; k++) begin
         if (k != 0) @(negedge clk);
         if (tx !== pat[k/D] || stdin_ack !== 1'b0) bad++;
      end
      chk({name, "_frame_errs"}, bad, 32'd0);
      @(negedge clk);
      chk({name, "_ack_end"}, {31'b0, stdin_ack}, 32'd1);
      chk({name, "_tx_idle"}, {31'b0, tx}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      fails++;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int bad;
      int nf;
      int ng;

      repeat (3) @(negedge clk);
      chk("reset_tx", {31'b0, tx}, 32'd1);
      chk("reset_ack", {31'b0, stdin_ack}, 32'd0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1 chk("ack_after_reset", {31'b0, stdin_ack}, 32'd1);

      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1 || stdin_ack !== 1'b1) bad++;
      end
      chk("idle_errs", bad, 32'd0);

      send_check(32'h000000A5, 10'b1_10100101_0, "a5");
      repeat (3) @(negedge clk);
      send_check(32'hFFFFFF00, 10'b1_00000000_0, "upper");

      // Back-to-back with strobe held.
      repeat (3) @(negedge clk);
      nf = fall_q.size();
      ng = rx_got.size();
      @(negedge clk);
      stdin     = 32'h00000055;
      stdin_stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      stdin = 32'h0000000F;
      repeat (101) @(negedge clk);
      stdin_stb = 1'b0;
      repeat (110) @(negedge clk);
      chk("b2b_falls", fall_q.size() - nf, 32'd2);
      if (fall_q.size() >= nf + 2)
         chk("b2b_spacing", 32'((fall_q[nf+1] - fall_q[nf]) / 10), 32'd101);
      if (rx_got.size() >= ng + 2) begin
         chk("b2b_byte0", {24'b0, rx_got[ng]}, 32'h55);
         chk("b2b_byte1", {24'b0, rx_got[ng+1]}, 32'h0F);
      end

      // Backpressure: strobe raised mid-frame.
      repeat (3) @(negedge clk);
      ng = rx_got.size();
      @(negedge clk);
      stdin     = 32'h00000096;
      stdin_stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      stdin_stb = 1'b0;
      repeat (29) @(negedge clk);
      stdin     = 32'h00000081;
      stdin_stb = 1'b1;
      bad = 0;
      repeat (70) begin
         @(negedge clk);
         if (stdin_ack !== 1'b0) bad++;
      end
      chk("bp_ack_low", bad, 32'd0);
      @(negedge clk);
      chk("bp_ack_end", {31'b0, stdin_ack}, 32'd1);
      @(negedge clk);
      stdin_stb = 1'b0;
      chk("bp_ack_taken", {31'b0, stdin_ack}, 32'd0);
      repeat (110) @(negedge clk);
      chk("bp_frames", rx_got.size() - ng, 32'd2);
      if (rx_got.size() >= ng + 2) begin
         chk("bp_byte0", {24'b0, rx_got[ng]}, 32'h96);
         chk("bp_byte1", {24'b0, rx_got[ng+1]}, 32'h81);
      end

      // Reset during data bit 3.
      repeat (3) @(negedge clk);
      @(negedge clk);
      stdin     = 32'h000000C3;
      stdin_stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      stdin_stb = 1'b0;
      repeat (46) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_tx", {31'b0, tx}, 32'd1);
      chk("rst_mid_ack", {31'b0, stdin_ack}, 32'd0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1 chk("rst_release_ack", {31'b0, stdin_ack}, 32'd1);
      ng = rx_got.size();
      repeat (200) @(negedge clk);
      chk("rst_no_resend", rx_got.size() - ng, 32'd0);
      send_check(32'h0000003C, 10'b1_00111100_0, "after_rst");

      // Randomized traffic; model and receiver check every cycle and byte.
      for (int it = 0; it < 20; it++) begin
         repeat ($urandom_range(0, 15)) begin
            @(negedge clk);
            stdin = $urandom;
         end
         @(negedge clk);
         stdin     = $urandom;
         stdin_stb = 1'b1;
         repeat ($urandom_range(1, 250)) begin
            @(negedge clk);
            stdin = $urandom;
         end
         stdin_stb = 1'b0;
         repeat (120) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("rx_exp_empty", rx_exp.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
